// File: rtl/flag_branch_unit_pkg.sv
// ISA encodings, flag bit positions and branch-unit types shared by the
// execute-stage flag register and the branch condition evaluator.
package flag_branch_unit_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;
  localparam logic [3:0] OP_LW     = 4'd8;
  localparam logic [3:0] OP_SW     = 4'd9;
  localparam logic [3:0] OP_LHB    = 4'd10;
  localparam logic [3:0] OP_LLB    = 4'd11;
  localparam logic [3:0] OP_B      = 4'd12;
  localparam logic [3:0] OP_BR     = 4'd13;
  localparam logic [3:0] OP_PCS    = 4'd14;
  localparam logic [3:0] OP_HLT    = 4'd15;

  localparam logic [2:0] CC_NEQ    = 3'd0;
  localparam logic [2:0] CC_EQ     = 3'd1;
  localparam logic [2:0] CC_GT     = 3'd2;
  localparam logic [2:0] CC_LT     = 3'd3;
  localparam logic [2:0] CC_GTE    = 3'd4;
  localparam logic [2:0] CC_LTE    = 3'd5;
  localparam logic [2:0] CC_OVFL   = 3'd6;
  localparam logic [2:0] CC_UNCOND = 3'd7;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic {
    BR_IDLE,
    BR_WAIT
  } br_state_t;

  // Which {Z,V,N} bits an EX opcode is allowed to update.
  function automatic logic [2:0] flag_wmask(input logic [3:0] op);
    logic [2:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = '1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Branch condition evaluator: pure combinational map from {Z,V,N} and the
// ccc field to a taken decision. Shared by every stage that resolves BR.
module cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] flags_i,
  input  logic [2:0] ccc_i,
  output logic       taken_o
);

  logic z;
  logic v;
  logic n;

  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];

  // Decode the condition code against the supplied flags.
  always_comb begin
    taken_o = 1'b0;
    case (ccc_i)
      CC_NEQ:    taken_o = ~z;
      CC_EQ:     taken_o = z;
      CC_GT:     taken_o = ~z & ~n;
      CC_LT:     taken_o = n;
      CC_GTE:    taken_o = z | ~n;
      CC_LTE:    taken_o = n | z;
      CC_OVFL:   taken_o = v;
      CC_UNCOND: taken_o = 1'b1;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register plus B/BR resolution for the instruction in ID.
// A branch behind a flag-writing EX instruction waits until that writer has
// committed, then resolves against the updated flags.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic       ex_hold,
  input  logic [3:0] ex_op,
  input  logic [2:0] ex_flags,
  input  logic       id_valid,
  input  logic [3:0] id_op,
  input  logic [2:0] id_cond,
  output logic [2:0] flags,
  output logic       br_stall,
  output logic       br_resolve,
  output logic       br_taken
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic [2:0] wmask;
  logic       commit;
  logic       is_branch;
  logic       hazard;
  logic       cond_taken;
  logic       hold_q;
  logic       stall_d;
  logic       resolve_d;
  br_state_t  state_q;
  br_state_t  state_d;

  cond_eval u_cond_eval (
    .flags_i (flags_q),
    .ccc_i   (id_cond),
    .taken_o (cond_taken)
  );

  // Masked flag update for an EX instruction that leaves the stage.
  always_comb begin
    wmask     = flag_wmask(ex_op);
    commit    = ex_valid & ~ex_hold;
    flags_d   = commit ? ((flags_q & ~wmask) | (ex_flags & wmask)) : flags_q;
    is_branch = id_valid & ((id_op == OP_B) | (id_op == OP_BR));
    hazard    = is_branch & ex_valid & (|wmask);
  end

  // Flag register and EX-hold history; hold_q low in WAIT means the writer
  // left EX on the previous edge, so flags_q now holds its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      hold_q  <= ex_hold;
    end
  end

  // Branch FSM next state and stall/resolve decode.
  always_comb begin
    state_d   = state_q;
    stall_d   = 1'b0;
    resolve_d = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (hazard) begin
          stall_d = 1'b1;
          state_d = BR_WAIT;
        end else if (is_branch) begin
          resolve_d = 1'b1;
        end
      end
      BR_WAIT: begin
        if (!id_valid) begin
          state_d = BR_IDLE;
        end else if (hold_q) begin
          stall_d = 1'b1;
        end else begin
          resolve_d = 1'b1;
          state_d   = BR_IDLE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
    if (rst) begin
      stall_d   = 1'b0;
      resolve_d = 1'b0;
    end
  end

  // Branch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign flags      = flags_q;
  assign br_stall   = stall_d;
  assign br_resolve = resolve_d;
  assign br_taken   = resolve_d & cond_taken;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed sequences, a full
// condition/flag sweep table, and a randomized run against a reference model.
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic       ex_hold;
  logic [3:0] ex_op;
  logic [2:0] ex_flags;
  logic       id_valid;
  logic [3:0] id_op;
  logic [2:0] id_cond;
  logic [2:0] flags;
  logic       br_stall;
  logic       br_resolve;
  logic       br_taken;

  int checks = 0;
  int errors = 0;

  flag_branch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_hold    (ex_hold),
    .ex_op      (ex_op),
    .ex_flags   (ex_flags),
    .id_valid   (id_valid),
    .id_op      (id_op),
    .id_cond    (id_cond),
    .flags      (flags),
    .br_stall   (br_stall),
    .br_resolve (br_resolve),
    .br_taken   (br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] f;
    logic [2:0] c;
    logic       exp;
  } vec_t;

  vec_t tbl[64];

  // Condition list written out directly in terms of Z, V, N.
  function automatic logic ref_taken(input logic [2:0] f, input logic [2:0] c);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one edge, then apply new inputs shortly after it.
  task automatic drive(input logic r, input logic ev, input logic eh, input logic [3:0] eo,
                       input logic [2:0] ef, input logic iv, input logic [3:0] io,
                       input logic [2:0] ic);
    @(posedge clk);
    #1;
    rst = r; ex_valid = ev; ex_hold = eh; ex_op = eo; ex_flags = ef;
    id_valid = iv; id_op = io; id_cond = ic;
    @(negedge clk);
  endtask

  task automatic chk_br(input string name, input logic s, input logic r, input logic t);
    chk({name, ".stall"}, {3'b0, br_stall}, {3'b0, s});
    chk({name, ".resolve"}, {3'b0, br_resolve}, {3'b0, r});
    if (r) chk({name, ".taken"}, {3'b0, br_taken}, {3'b0, t});
  endtask

  // Reference model state for the random run.
  logic [2:0] m_flags;
  bit         m_wait;
  bit         m_done;

  initial begin
    rst = 1'b1; ex_valid = 0; ex_hold = 0; ex_op = 0; ex_flags = 0;
    id_valid = 0; id_op = 0; id_cond = 0;

    for (int f = 0; f < 8; f++)
      for (int c = 0; c < 8; c++)
        tbl[f*8+c] = '{f[2:0], c[2:0], ref_taken(f[2:0], c[2:0])};

    // Reset cycle with a hazard pattern on the inputs: outputs must stay low.
    drive(1, 1, 0, 4'd0, 3'b111, 1, 4'd12, 3'd7);
    chk_br("rst_cycle", 0, 0, 0);
    chk("rst_cycle.taken", {3'b0, br_taken}, 4'h0);
    drive(0, 0, 0, 4'd0, 3'b000, 0, 4'd0, 3'd0);
    chk("after_rst.flags", {1'b0, flags}, 4'h0);

    // ADD 110 ahead of B EQ: one stall cycle, then taken.
    drive(0, 1, 0, 4'd0, 3'b110, 1, 4'd12, 3'd1);
    chk_br("add_beq.c0", 1, 0, 0);
    drive(0, 0, 0, 4'd0, 3'b000, 1, 4'd12, 3'd1);
    chk("add_beq.flags", {1'b0, flags}, 4'h6);
    chk_br("add_beq.c1", 0, 1, 1);

    // XOR only writes Z.
    drive(0, 1, 0, 4'd0, 3'b000, 0, 4'd0, 3'd0);
    drive(0, 1, 0, 4'd2, 3'b011, 0, 4'd0, 3'd0);
    chk("clr.flags", {1'b0, flags}, 4'h0);
    drive(0, 1, 0, 4'd2, 3'b111, 0, 4'd0, 3'd0);
    chk("xor011.flags", {1'b0, flags}, 4'h0);
    drive(0, 0, 0, 4'd0, 3'b000, 0, 4'd0, 3'd0);
    chk("xor111.flags", {1'b0, flags}, 4'h4);

    // Flag-free PADDSB in EX does not stall BR OVFL.
    drive(0, 1, 0, 4'd0, 3'b010, 0, 4'd0, 3'd0);
    drive(0, 1, 0, 4'd7, 3'b101, 1, 4'd13, 3'd6);
    chk("paddsb.flags", {1'b0, flags}, 4'h2);
    chk_br("paddsb_ovfl", 0, 1, 1);

    // SUB 001 held two cycles ahead of B GTE: three stalls, then not taken.
    drive(0, 1, 1, 4'd1, 3'b001, 1, 4'd12, 3'd4);
    chk_br("sub_hold.c0", 1, 0, 0);
    drive(0, 1, 1, 4'd1, 3'b001, 1, 4'd12, 3'd4);
    chk_br("sub_hold.c1", 1, 0, 0);
    drive(0, 1, 0, 4'd1, 3'b001, 1, 4'd12, 3'd4);
    chk_br("sub_hold.c2", 1, 0, 0);
    chk("sub_hold.c2.flags", {1'b0, flags}, 4'h2);
    drive(0, 0, 0, 4'd0, 3'b000, 1, 4'd12, 3'd4);
    chk_br("sub_hold.c3", 0, 1, 0);
    chk("sub_hold.flags", {1'b0, flags}, 4'h1);

    // Back-to-back branches each resolve against the current flags.
    drive(0, 0, 0, 4'd0, 3'b000, 1, 4'd13, 3'd3);
    chk_br("b2b.lt", 0, 1, 1);
    drive(0, 0, 0, 4'd0, 3'b000, 1, 4'd12, 3'd1);
    chk_br("b2b.eq", 0, 1, 0);

    // Flush during WAIT: no resolve, back to normal afterwards.
    drive(0, 1, 1, 4'd0, 3'b100, 1, 4'd12, 3'd7);
    chk_br("flush.c0", 1, 0, 0);
    drive(0, 1, 0, 4'd0, 3'b100, 0, 4'd12, 3'd7);
    chk_br("flush.c1", 0, 0, 0);
    drive(0, 0, 0, 4'd0, 3'b000, 1, 4'd12, 3'd1);
    chk_br("flush.c2", 0, 1, 1);

    // Condition sweep: load flags through ADD, then resolve without a hazard.
    for (int i = 0; i < 64; i++) begin
      drive(0, 1, 0, 4'd0, tbl[i].f, 0, 4'd0, 3'd0);
      drive(0, 0, 0, 4'd0, 3'b000, 1, (i % 2 == 0) ? 4'd12 : 4'd13, tbl[i].c);
      chk("sweep.resolve", {3'b0, br_resolve}, 4'h1);
      chk($sformatf("sweep.f%0d.c%0d", tbl[i].f, tbl[i].c), {3'b0, br_taken}, {3'b0, tbl[i].exp});
    end

    // Reset asserted while in WAIT aborts the branch and drops the ADD.
    drive(0, 1, 1, 4'd0, 3'b111, 1, 4'd12, 3'd7);
    chk_br("rst_wait.c0", 1, 0, 0);
    drive(1, 1, 0, 4'd0, 3'b111, 1, 4'd12, 3'd7);
    chk_br("rst_wait.c1", 0, 0, 0);
    drive(0, 0, 0, 4'd0, 3'b000, 0, 4'd0, 3'd0);
    chk("rst_wait.flags", {1'b0, flags}, 4'h0);
    chk_br("rst_wait.c2", 0, 0, 0);

    // Randomized run against the reference model.
    m_flags = '0; m_wait = 0; m_done = 0;
    for (int k = 0; k < 400; k++) begin
      logic r, ev, eh, iv, br, wr, e_s, e_r;
      logic [3:0] eo, io;
      logic [2:0] ef, ic;
      r  = ($urandom_range(0, 59) == 0);
      ev = ($urandom_range(0, 3) != 0);
      eh = ($urandom_range(0, 3) == 0);
      eo = 4'($urandom_range(0, 15));
      ef = 3'($urandom_range(0, 7));
      if (m_wait) begin
        iv = ($urandom_range(0, 9) != 0);
        io = id_op; ic = id_cond;
      end else begin
        iv = ($urandom_range(0, 4) != 0);
        io = ($urandom_range(0, 2) != 0) ? 4'(12 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
        ic = 3'($urandom_range(0, 7));
      end
      drive(r, ev, eh, eo, ef, iv, io, ic);

      br = iv && (io == 4'd12 || io == 4'd13);
      wr = (eo inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6});
      e_s = 0; e_r = 0;
      if (!r) begin
        chk("rand.flags", {1'b0, flags}, {1'b0, m_flags});
        if (!m_wait) begin
          if (br && ev && wr) begin
            e_s = 1; m_wait = 1; m_done = !eh;
          end else if (br) begin
            e_r = 1;
          end
        end else if (!iv) begin
          m_wait = 0;
        end else if (m_done) begin
          e_r = 1; m_wait = 0;
        end else begin
          e_s = 1; m_done = !eh;
        end
      end else begin
        m_wait = 0;
      end
      chk_br("rand", e_s, e_r, ref_taken(m_flags, ic));

      if (r) m_flags = '0;
      else if (ev && !eh) begin
        if (eo <= 4'd1) m_flags = ef;
        else if (wr) m_flags[2] = ef[2];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Execute-stage flag register and branch-condition evaluator for the 16-bit pipelined core. It consumes the `{Z,V,N}` flag vector that the ALU produces in EX and commits only the bits the EX opcode is allowed to write. It resolves B/BR conditions for the instruction in ID against the committed flags. When a flag-writing instruction is still in EX, it stalls the branch for one cycle, or longer if EX is held.

## Interface
Parameters: none. Opcode and condition encodings are fixed by the ISA package.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  the EX stage holds a real, non-flushed instruction.
- `ex_hold`  in  1  EX is frozen this cycle and does not advance to MEM.
- `ex_op`  in  4  opcode of the EX instruction, `inst[15:12]`.
- `ex_flags`  in  3  ALU flags `{Z,V,N}` for the EX instruction.
- `id_valid`  in  1  the ID stage holds a real instruction.
- `id_op`  in  4  opcode of the ID instruction.
- `id_cond`  in  3  condition field `ccc` of the ID instruction.
- `flags`  out  3  committed `{Z,V,N}` register.
- `br_stall`  out  1  hold PC and IF/ID, and inject a bubble into EX.
- `br_resolve`  out  1  a branch in ID is resolved this cycle.
- `br_taken`  out  1  resolved branch is taken; valid only when `br_resolve` is 1.

## Operation
- Flag write masks, applied to `ex_op`:
  - ADD (0) and SUB (1) write Z, V and N.
  - XOR (2), SLL (4), SRA (5) and ROR (6) write Z only.
  - RED (3), PADDSB (7) and opcodes 8–15 write nothing.
- Commit condition: `ex_valid & ~ex_hold`. Bits outside the mask keep their old value.
- The branch is identified by `id_op` equal to 12 (B) or 13 (BR), qualified by `id_valid`.
- Hazard: a branch is in ID while `ex_valid` is 1 and `ex_op` writes any flag bit.
- Conditions, evaluated on the registered `flags`:
  - 0 NEQ: Z=0.
  - 1 EQ: Z=1.
  - 2 GT: Z=0 and N=0.
  - 3 LT: N=1.
  - 4 GTE: Z=1, or Z=0 and N=0.
  - 5 LTE: N=1 or Z=1.
  - 6 OVFL: V=1.
  - 7 always taken.
- FSM states:
  - IDLE: on a hazard, set `br_stall`=1 and `br_resolve`=0, then go to WAIT. With a branch and no hazard, resolve this cycle and stay in IDLE.
  - WAIT: hold `br_stall`=1 while `ex_hold`=1. Once the EX writer has committed (`ex_hold` was 0 on the entry edge), the next cycle resolves with the new flags and returns to IDLE.
- A non-branch instruction in ID never stalls.
- If `id_valid` drops while in WAIT (a flush), return to IDLE without resolving.
- Reset behaviour:
  - `flags`=000 and the state is IDLE.
  - `br_stall`, `br_resolve` and `br_taken` are 0 during the reset cycle, regardless of the other inputs.
  - Reset asserted in WAIT aborts the pending branch.

## Timing
- Flag latency: ALU flags in cycle N are visible on `flags` in cycle N+1.
- Branch with no hazard: `br_resolve` and `br_taken` are combinational from `flags`, `id_op` and `id_cond` in the same cycle.
- Branch behind a flag writer: stalled 1 cycle, resolves in the 2nd cycle. Each cycle of `ex_hold` adds one more stall cycle.
- `br_stall` is combinational from the ID/EX inputs and the FSM state, so it reaches the hazard mux in the same cycle.
- Commit and flush in the same cycle: if `ex_valid`=0, nothing commits.
- Back-to-back branches: each one evaluates independently against the current `flags`.

## Structure
- The shared ISA package holds:
  - opcode localparams `OP_ADD`..`OP_HLT`;
  - condition localparams `CC_NEQ`..`CC_UNCOND`;
  - flag bit indices `FLAG_Z`=2, `FLAG_V`=1, `FLAG_N`=0.
- One sub-module is natural: `cond_eval`, a purely combinational function of (`flags`, `ccc`) to `taken`. BR resolution in other stages reuses it.
- The flag register, write-mask decode and FSM stay in the top level.

## Test plan
- Reset, then ADD with ALU flags 110 committed → `flags`=110 next cycle; with a B EQ in ID: `br_stall`=1 for 1 cycle, then `br_resolve`=1, `br_taken`=1.
- `flags`=000, XOR with ALU flags 011 → `flags`=000, because V and N are masked and Z=0.
- `flags`=010, PADDSB in EX and a BR OVFL in ID → `br_stall`=0, `br_resolve`=1, `br_taken`=1 in the same cycle.
- SUB with ALU flags 001 in EX while `ex_hold`=1 for 2 cycles, with B GTE in ID → `br_stall`=1 for 3 cycles, then `br_taken`=0 with `flags`=001.
- Each of the 8 conditions swept over all 8 flag values → `br_taken` matches the condition list exactly, 64 checks.
- `rst` asserted while in WAIT → the next cycle has `flags`=000, `br_stall`=0, `br_resolve`=0; the ADD that was in EX that cycle does not commit.
